// File: rtl/debounce_pkg.sv
// Shared limits and defaults for the debounce stages.
// Leaf helpers only: no logic, no latency, no flow control.
package debounce_pkg;

   localparam int DEBOUNCE_DEFAULT_CYCLES = 4;
   localparam int DEBOUNCE_MIN_CYCLES     = 2;
   localparam int DEBOUNCE_MAX_CYCLES     = 255;

   function automatic bit debounce_cycles_legal(input int cycles);
      return (cycles >= DEBOUNCE_MIN_CYCLES) && (cycles <= DEBOUNCE_MAX_CYCLES);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One-channel sync + debounce with registered rise/fall pulses; raw-to-level latency STABLE_CYCLES+2.
// No backpressure: a free-running level conditioner, every output a flop.
module debounce_bit
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int                CNT_W   = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             lvl_q,   lvl_d;
   logic             rise_q,  rise_d;
   logic             fall_q,  fall_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      lvl_d   = lvl_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      // Any sample matching the held level restarts the qualification window.
      if (sync2_q != lvl_q) begin
         if (cnt_q == CNT_MAX) begin
            lvl_d  = sync2_q;
            rise_d = sync2_q;
            fall_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         lvl_q   <= 1'b0;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         lvl_q   <= lvl_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = lvl_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/input_debounce_pair.sv
// Two independent debounced channels feeding the combine stage; latency STABLE_CYCLES+2.
// No backpressure: outputs are registered levels and single-cycle event pulses.
module input_debounce_pair
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DEBOUNCE_DEFAULT_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic a_raw,
   input  logic b_raw,
   output logic a,
   output logic b,
   output logic a_rise,
   output logic a_fall,
   output logic b_rise,
   output logic b_fall
);

   if (!debounce_cycles_legal(STABLE_CYCLES)) begin : g_bad_cycles
      $error("input_debounce_pair: STABLE_CYCLES=%0d outside %0d..%0d",
             STABLE_CYCLES, DEBOUNCE_MIN_CYCLES, DEBOUNCE_MAX_CYCLES);
   end

   debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_chan_a (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (a_raw),
      .level (a),
      .rise  (a_rise),
      .fall  (a_fall)
   );

   debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_chan_b (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (b_raw),
      .level (b),
      .rise  (b_rise),
      .fall  (b_fall)
   );

endmodule

// File: tb/tb_input_debounce_pair.sv
// Randomised and directed bench for input_debounce_pair against a sample-window reference model.
module tb_input_debounce_pair;

   localparam int N = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic a_raw = 1'b0;
   logic b_raw = 1'b0;
   logic a, b, a_rise, a_fall, b_rise, b_fall;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   input_debounce_pair #(.STABLE_CYCLES(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a_raw  (a_raw),
      .b_raw  (b_raw),
      .a      (a),
      .b      (b),
      .a_rise (a_rise),
      .a_fall (a_fall),
      .b_rise (b_rise),
      .b_fall (b_fall)
   );

   wire [5:0] dut_out = {a, b, a_rise, a_fall, b_rise, b_fall};

   // Reference: s is the raw value seen two edges earlier; a channel adopts s
   // when the last N samples of s all disagree with its current level.
   logic [1:0] m_raw_q[$];
   logic [1:0] m_s_q[$];
   logic [1:0] m_lvl  = 2'b00;
   logic [1:0] m_rise = 2'b00;
   logic [1:0] m_fall = 2'b00;

   always @(posedge clk) begin
      logic [1:0] s;
      bit         steady;
      if (!rst_n) begin
         m_raw_q = {2'b00, 2'b00};
         m_s_q   = {};
         m_lvl   = 2'b00;
         m_rise  = 2'b00;
         m_fall  = 2'b00;
      end else begin
         m_raw_q.push_back({b_raw, a_raw});
         s = m_raw_q.pop_front();
         m_s_q.push_back(s);
         if (m_s_q.size() > N) void'(m_s_q.pop_front());
         m_rise = 2'b00;
         m_fall = 2'b00;
         for (int c = 0; c < 2; c++) begin
            steady = (m_s_q.size() == N);
            foreach (m_s_q[k]) if (m_s_q[k][c] == m_lvl[c]) steady = 0;
            if (steady) begin
               m_lvl[c]  = s[c];
               m_rise[c] = s[c];
               m_fall[c] = ~s[c];
            end
         end
      end
   end

   wire [5:0] m_out = {m_lvl[0], m_lvl[1], m_rise[0], m_fall[0], m_rise[1], m_fall[1]};

   // Stimulus only: holds reset for two edges, returns at a falling edge.
   task automatic do_reset(input logic av, input logic bv);
      rst_n = 1'b0; a_raw = av; b_raw = bv;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); @(negedge clk); end
   endtask

   task automatic test_reset;
      logic [5:0] exp_v;
      @(negedge clk);
      do_reset(1'b1, 1'b1);
      vectors++;
      if (dut_out !== 6'b000000) begin
         miscompares++;
         $display("FAIL reset_hold: got %b want %b", dut_out, 6'b000000);
      end
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk); @(negedge clk);
         exp_v = (i < 6) ? 6'b000000 : (i == 6) ? 6'b111010 : 6'b110000;
         vectors++;
         if (dut_out !== exp_v) begin
            miscompares++;
            $display("FAIL reset_release edge %0d: got %b want %b", i, dut_out, exp_v);
         end
         vectors++;
         if (dut_out !== m_out) begin
            miscompares++;
            $display("FAIL reset_release_model edge %0d: got %b want %b", i, dut_out, m_out);
         end
      end
   endtask

   task automatic test_clean_rise;
      logic [5:0] exp_v;
      do_reset(1'b0, 1'b0);
      idle(3);
      a_raw = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); @(negedge clk);
         exp_v = {i >= 6, 1'b0, i == 6, 3'b000};
         vectors++;
         if (dut_out !== exp_v) begin
            miscompares++;
            $display("FAIL clean_rise edge %0d: got %b want %b", i, dut_out, exp_v);
         end
      end
   endtask

   task automatic test_glitch;
      logic [5:0] exp_v;
      do_reset(1'b0, 1'b0);
      idle(3);
      for (int i = 1; i <= 12; i++) begin
         a_raw = (i <= 3);
         @(posedge clk); @(negedge clk);
         vectors++;
         if (dut_out !== 6'b000000) begin
            miscompares++;
            $display("FAIL glitch_3 edge %0d: got %b want %b", i, dut_out, 6'b000000);
         end
      end
      for (int i = 1; i <= 14; i++) begin
         a_raw = (i <= 4);
         @(posedge clk); @(negedge clk);
         exp_v = {(i >= 6) && (i < 10), 1'b0, i == 6, i == 10, 2'b00};
         vectors++;
         if (dut_out !== exp_v) begin
            miscompares++;
            $display("FAIL glitch_4 edge %0d: got %b want %b", i, dut_out, exp_v);
         end
      end
   endtask

   task automatic test_bounce;
      logic [5:0] exp_v;
      int rises = 0;
      do_reset(1'b0, 1'b0);
      idle(3);
      for (int i = 1; i <= 14; i++) begin
         a_raw = (i >= 5) ? 1'b1 : logic'(i % 2);
         @(posedge clk); @(negedge clk);
         if (a_rise) rises++;
         exp_v = {i >= 10, 1'b0, i == 10, 3'b000};
         vectors++;
         if (dut_out !== exp_v) begin
            miscompares++;
            $display("FAIL bounce edge %0d: got %b want %b", i, dut_out, exp_v);
         end
      end
      vectors++;
      if (rises != 1) begin
         miscompares++;
         $display("FAIL bounce_rise_count: got %0d want 1", rises);
      end
   endtask

   task automatic test_simultaneous;
      logic [5:0] exp_v;
      do_reset(1'b0, 1'b0);
      idle(3);
      a_raw = 1'b1; b_raw = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         @(posedge clk); @(negedge clk);
         exp_v = (i < 6) ? 6'b000000 : (i == 6) ? 6'b111010 : 6'b110000;
         vectors++;
         if (dut_out !== exp_v) begin
            miscompares++;
            $display("FAIL simultaneous edge %0d: got %b want %b", i, dut_out, exp_v);
         end
      end
   endtask

   task automatic test_mid_reset;
      logic [5:0] exp_v;
      do_reset(1'b0, 1'b0);
      idle(3);
      a_raw = 1'b1; b_raw = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         rst_n = !((i == 3) || (i == 4));
         @(posedge clk); @(negedge clk);
         exp_v = (i < 10) ? 6'b000000 : (i == 10) ? 6'b111010 : 6'b110000;
         vectors++;
         if (dut_out !== exp_v) begin
            miscompares++;
            $display("FAIL mid_reset edge %0d: got %b want %b", i, dut_out, exp_v);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_random;
      do_reset(1'b0, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) a_raw = ~a_raw;
         if ($urandom_range(0, 5) == 0) b_raw = ~b_raw;
         rst_n = ($urandom_range(0, 399) != 0);
         @(posedge clk); @(negedge clk);
         vectors++;
         if (dut_out !== m_out) begin
            miscompares++;
            $display("FAIL random cycle %0d: got %b want %b", i, dut_out, m_out);
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_clean_rise();
      test_glitch();
      test_bounce();
      test_simultaneous();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
